// File: rtl/mem_arb_pkg.sv
// Shared constants, port indices and FSM encoding for the memory data-port arbiter.
package mem_arb_pkg;

    localparam logic [31:0] DATA_TOP_DEF = 32'h2FFC;
    localparam logic [31:0] INST_BASE    = 32'h3000;

    localparam int unsigned P_CPU = 0;
    localparam int unsigned P_DMA = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/mem_data_arbiter_rr_pick2.sv
// Two-way combinational round-robin picker; on a tie the port not granted last time wins.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant_valid,
    output logic       winner
);

    always_comb begin
        grant_valid = |req;
        winner      = 1'b0;
        case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last;
            default: winner = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_data_arbiter.sv
// Arbitrates Memory's data port between the CPU (port 0) and the DMA/debug loader (port 1).
// Optional address range checking is enabled by defining MEMARB_RANGE_CHECK_EN.
module mem_data_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
`ifdef MEMARB_RANGE_CHECK_EN
    ,
    parameter logic [ADDR_W-1:0] DATA_TOP = ADDR_W'(DATA_TOP_DEF)
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        ack,
    output logic [1:0]        err,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e            state_q, state_d;
    logic              last_q, win_q, we_q, bad_q;
    logic              grant_valid, winner;
    logic              sel_we, sel_bad;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    logic [1:0]        ack_d, err_d;
    logic [DATA_W-1:0] rdata_d, mem_wdata_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic              mem_read_d, mem_write_d;

    rr_pick2 u_pick (
        .req         (req),
        .last        (last_q),
        .grant_valid (grant_valid),
        .winner      (winner)
    );

    // Winner's request fields and legality
    always_comb begin
        sel_we    = we[winner];
        sel_addr  = (winner == 1'(P_DMA)) ? addr1 : addr0;
        sel_wdata = (winner == 1'(P_DMA)) ? wdata1 : wdata0;
`ifdef MEMARB_RANGE_CHECK_EN
        sel_bad   = (sel_addr[1:0] != 2'b00) || (sel_addr > DATA_TOP);
`else
        sel_bad   = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (grant_valid) state_d = ST_ACCESS;
            ST_ACCESS: state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; mem_* are set up so they are live during ACCESS
    always_comb begin
        ack_d       = 2'b00;
        err_d       = 2'b00;
        rdata_d     = '0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid && !sel_bad) begin
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                    mem_read_d  = !sel_we;
                    mem_write_d = sel_we;
                end
            end
            ST_ACCESS: begin
                ack_d[win_q] = 1'b1;
                err_d[win_q] = bad_q;
                if (!we_q && !bad_q) rdata_d = mem_rdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q    <= 1'b1;
            win_q     <= 1'b0;
            we_q      <= 1'b0;
            bad_q     <= 1'b0;
            ack       <= 2'b00;
            err       <= 2'b00;
            rdata     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && grant_valid) begin
                last_q <= winner;
                win_q  <= winner;
                we_q   <= sel_we;
                bad_q  <= sel_bad;
            end
            ack       <= ack_d;
            err       <= err_d;
            rdata     <= rdata_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            mem_read  <= mem_read_d;
            mem_write <= mem_write_d;
        end
    end

endmodule

// File: tb/tb_mem_data_arbiter.sv
// Directed bench for mem_data_arbiter with a word-addressed memory model on the data port.
module tb_mem_data_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req, we, ack, err;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write;

    logic [31:0] mem [0:4095];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    function automatic logic [11:0] widx(input logic [31:0] a);
        return 12'(a >> 2);
    endfunction

    assign mem_rdata = mem[widx(mem_addr)];
    always @(posedge clk) if (mem_write) mem[widx(mem_addr)] <= mem_wdata;

    mem_data_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .we        (we),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .ack       (ack),
        .err       (err),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_rdata (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One transaction from an IDLE negedge; returns at the following IDLE negedge
    task automatic xfer(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [1:0] ack_o, output logic [1:0] err_o,
                        output logic [31:0] rd, output int wr_cycles, output logic [31:0] acc_addr);
        we[p] = w;
        if (p == 0) begin addr0 = a; wdata0 = d; end
        else        begin addr1 = a; wdata1 = d; end
        req[p]    = 1'b1;
        lat       = -1;
        wr_cycles = 0;
        ack_o     = 2'b00;
        err_o     = 2'b00;
        rd        = 32'hXXXX_XXXX;
        acc_addr  = 32'hFFFF_FFFF;
        for (int i = 1; i <= 8 && lat < 0; i++) begin
            @(negedge clk);
            if (mem_write) wr_cycles++;
            if (mem_read || mem_write) acc_addr = mem_addr;
            if (ack != 2'b00) begin
                lat = i; ack_o = ack; err_o = err; rd = rdata;
            end
        end
        req[p] = 1'b0;
        @(negedge clk);
    endtask

    int          lat, wrc;
    logic [1:0]  a_o, e_o;
    logic [31:0] rd, aa;
    logic [1:0]  exp_ack;

    initial begin
        rst_n = 1'b0; req = 2'b00; we = 2'b00;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        mem[0]      = 32'h1234_5678;
        mem[12'hBFF] = 32'h0BAD_F00D;
        mem[12'hC00] = 32'hCAFE_0000;

        repeat (2) @(negedge clk);
        chk("rst_ctl", {28'h0, ack, err}, 32'h0);
        chk("rst_mem_rw", {30'h0, mem_read, mem_write}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        rst_n = 1'b1;

        // T1: reset asserted during ACCESS of a load
        @(negedge clk);
        we[0] = 1'b0; addr0 = 32'h0; req[0] = 1'b1;
        @(negedge clk);
        chk("t1_access_read", {31'h0, mem_read}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("t1_async_ctl", {28'h0, ack, err}, 32'h0);
        chk("t1_async_rw", {30'h0, mem_read, mem_write}, 32'h0);
        chk("t1_async_addr", mem_addr, 32'h0);
        req[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t1_no_ack", {30'h0, ack}, 32'h0);
        xfer(0, 1'b0, 32'h0, 32'h0, lat, a_o, e_o, rd, wrc, aa);
        chk("t1_lat", lat, 2);
        chk("t1_ack", {30'h0, a_o}, 32'h1);
        chk("t1_rdata", rd, 32'h1234_5678);
        chk("t1_rdata_idle", rdata, 32'h0);

        // T2: store then load through port 0
        xfer(0, 1'b1, 32'h10, 32'hDEAD_BEEF, lat, a_o, e_o, rd, wrc, aa);
        chk("t2_st_lat", lat, 2);
        chk("t2_st_ack", {30'h0, a_o}, 32'h1);
        chk("t2_st_wr_cycles", wrc, 1);
        chk("t2_st_addr", aa, 32'h10);
        chk("t2_st_rdata", rd, 32'h0);
        chk("t2_mem", mem[4], 32'hDEAD_BEEF);
        xfer(0, 1'b0, 32'h10, 32'h0, lat, a_o, e_o, rd, wrc, aa);
        chk("t2_ld_lat", lat, 2);
        chk("t2_ld_wr_cycles", wrc, 0);
        chk("t2_ld_rdata", rd, 32'hDEAD_BEEF);

        // T3: both ports held after reset alternate 0,1,0,1 every 3 cycles
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        we = 2'b00; addr0 = 32'h0; addr1 = 32'h10; req = 2'b11;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            exp_ack = (i == 2 || i == 8) ? 2'b01 : (i == 5 || i == 11) ? 2'b10 : 2'b00;
            chk($sformatf("t3_ack_c%0d", i), {30'h0, ack}, {30'h0, exp_ack});
            if (exp_ack == 2'b01) chk($sformatf("t3_rd0_c%0d", i), rdata, 32'h1234_5678);
            if (exp_ack == 2'b10) chk($sformatf("t3_rd1_c%0d", i), rdata, 32'hDEAD_BEEF);
            if (i == 11) req = 2'b00;
        end

        // T4: port 1 arrives during port 0's ACCESS, served right after port 0's ack
        we = 2'b00; addr0 = 32'h10; req[0] = 1'b1;
        @(negedge clk);
        addr1 = 32'h0; req[1] = 1'b1;
        @(negedge clk);
        chk("t4_ack0", {30'h0, ack}, 32'h1);
        chk("t4_rd0", rdata, 32'hDEAD_BEEF);
        req[0] = 1'b0;
        @(negedge clk);
        chk("t4_idle_ack", {30'h0, ack}, 32'h0);
        @(negedge clk);
        chk("t4_p1_access", {31'h0, mem_read}, 32'h1);
        chk("t4_p1_addr", mem_addr, 32'h0);
        @(negedge clk);
        chk("t4_ack1", {30'h0, ack}, 32'h2);
        chk("t4_rd1", rdata, 32'h1234_5678);
        req[1] = 1'b0;
        @(negedge clk);

`ifdef MEMARB_RANGE_CHECK_EN
        // T5: illegal accesses error out without touching Memory
        xfer(1, 1'b1, 32'h3000, 32'h55, lat, a_o, e_o, rd, wrc, aa);
        chk("t5_st_lat", lat, 2);
        chk("t5_st_ack", {30'h0, a_o}, 32'h2);
        chk("t5_st_err", {30'h0, e_o}, 32'h2);
        chk("t5_st_wr_cycles", wrc, 0);
        chk("t5_st_mem", mem[12'hC00], 32'hCAFE_0000);
        xfer(0, 1'b0, 32'h6, 32'h0, lat, a_o, e_o, rd, wrc, aa);
        chk("t5_mis_ack", {30'h0, a_o}, 32'h1);
        chk("t5_mis_err", {30'h0, e_o}, 32'h1);
        chk("t5_mis_rdata", rd, 32'h0);
        xfer(0, 1'b0, 32'h2FFC, 32'h0, lat, a_o, e_o, rd, wrc, aa);
        chk("t5_top_err", {30'h0, e_o}, 32'h0);
        chk("t5_top_rdata", rd, 32'h0BAD_F00D);
`else
        // T6: without range checking the same store reaches Memory
        xfer(1, 1'b1, 32'h3000, 32'h55, lat, a_o, e_o, rd, wrc, aa);
        chk("t6_st_lat", lat, 2);
        chk("t6_st_ack", {30'h0, a_o}, 32'h2);
        chk("t6_st_err", {30'h0, e_o}, 32'h0);
        chk("t6_st_wr_cycles", wrc, 1);
        chk("t6_st_mem", mem[12'hC00], 32'h55);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
